pc_trace_buffer: RTL and testbench
==================================

Name: pc_trace_buffer

Overview:
- Synthesizable PC trace capture unit that sits beside cpu_top and taps the committed PC stream.
- Records PC values with cycle timestamps into a parametrised circular buffer.
- Supports one-shot and trigger/post-trigger modes.
- Readout is oldest-first over a valid/ready handshake, so trace data is available in hardware as well as in simulation.

Parameters:
- PC_W, 32, width of the PC.
- DEPTH, 16, number of trace entries; must be a power of 2, at least 2.
- TS_W, 16, timestamp counter width; the counter wraps.
- POST_TRIG, 8, samples captured after the trigger in mode 1; range 0..DEPTH-1.
- CHG_ONLY, 1, when 1, a sample equal to the last recorded PC is dropped.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pc  in  PC_W  committed PC
- pc_valid  in  1  pc is valid this cycle
- arm  in  1  single-cycle pulse: clear and start capture
- mode  in  1  0 = one-shot (stop on full or trigger); 1 = circular with post-trigger
- trig_en  in  1  enable PC-match trigger
- trig_pc  in  PC_W  trigger PC value
- rd_valid  out  1  an entry is presented
- rd_ready  in  1  consumer accepts the entry
- rd_pc  out  PC_W  oldest entry PC
- rd_ts  out  TS_W  oldest entry timestamp
- state  out  2  FSM state
- triggered  out  1  trigger seen since arm
- count  out  $clog2(DEPTH)+1  valid entries held
- overflow  out  1  entries overwritten since arm

Behaviour:
- Reset (rst=1 at a clk edge, any state, including mid-capture or mid-readout):
  - state=IDLE; count, wr_ptr, triggered, overflow, post_cnt, ts_cnt = 0.
  - Last-PC-valid flag cleared; rd_valid=0.
  - RAM contents are not reset.
- Timestamp: ts_cnt increments every cycle and wraps modulo 2^TS_W. A written entry stores ts_cnt of its capture cycle.
- Accepted sample: pc_valid & (CHG_ONLY==0 | no last PC | pc != last_pc). Only accepted samples are written or counted. last_pc updates on each write.
- Write: mem[wr_ptr] <= {pc, ts_cnt}; wr_ptr increments and wraps modulo DEPTH. count increments and saturates at DEPTH.
- Write at count==DEPTH (mode 1 only): overwrites the oldest entry and sets overflow=1.
- Trigger: trig_en & pc_valid & pc==trig_pc, evaluated on the raw pc, independent of the filter. It acts in CAPTURE only.
- arm has priority over all other inputs in every state. It:
  - clears count, wr_ptr, triggered, overflow and the last-PC flag;
  - moves to CAPTURE next cycle;
  - does not capture a sample in the arm cycle.
- IDLE (0): no writes. rd_valid=0.
- CAPTURE (1):
  - Mode 0: a write making count==DEPTH -> DONE. A trigger sets triggered=1 and -> DONE; the trigger sample is written if accepted.
  - Mode 1: writes continue with wrap. A trigger sets triggered=1 and loads post_cnt=POST_TRIG. If POST_TRIG==0 -> DONE, else -> POST.
  - Trigger coinciding with overflow: the write happens, overflow=1, and the trigger transition applies.
- POST (2):
  - Each accepted write decrements post_cnt; the write that brings post_cnt to 0 -> DONE.
  - Further triggers are ignored; overwrite rules still apply.
- DONE (3):
  - No writes.
  - rd_valid = (count != 0).
  - rd_pc/rd_ts come combinationally from mem[(wr_ptr - count) mod DEPTH], show-ahead. Both are 0 whenever rd_valid=0.
  - Handshake: rd_valid & rd_ready decrements count at the edge. rd_pc/rd_ts hold stable while rd_ready=0.
  - The pop making count==0 -> IDLE. DONE entered with count==0 -> IDLE next cycle.
- Entering DONE adds no latency: data is readable in the first DONE cycle.
- mode is sampled in CAPTURE and POST every cycle. Software keeps it stable between arm and DONE; a change has no defined result beyond the rules above.

Decomposition:
- Shared package cpu_trace_pkg holds:
  - state encodings TR_IDLE=2'd0, TR_CAPTURE=2'd1, TR_POST=2'd2, TR_DONE=2'd3;
  - mode constants TR_ONESHOT=1'b0, TR_CIRC=1'b1.
- Sub-module trace_ram: DEPTH x (PC_W+TS_W) storage with one synchronous write port and one asynchronous read port.
- FSM, pointers and counters stay in pc_trace_buffer.

Test Plan (DEPTH=4, POST_TRIG=2, CHG_ONLY=1, TS_W=16):
1. Reset mid-operation: hold rst high 2 cycles while in CAPTURE with count=3 -> state=0, count=0, rd_valid=0, rd_pc=0, overflow=0, triggered=0.
2. Mode 0 fill: arm, then PCs 0x0,0x4,0x4,0x8,0xC with pc_valid=1 -> second 0x4 dropped, count=4, state=3. Readout with rd_ready=1 gives 0x0,0x4,0x8,0xC, then state=0.
3. Mode 1 trigger with overflow: trig_en=1, trig_pc=0x20, stream 0x00..0x28 step 4 -> triggered=1 at 0x20, DONE after 0x28, overflow=1. Readout gives 0x1C,0x20,0x24,0x28.
4. Backpressure: in DONE, rd_ready pattern 1,0,0,1,1,1 -> four pops. Outputs stay stable during the zeros; rd_valid drops after the 4th pop.
5. Timestamps: arm when ts_cnt=100, then valid PCs on every 3rd cycle -> consecutive rd_ts differ by exactly 3. Also cover ts wrap from 0xFFFF to 0x0000.
6. Re-arm during readout: after 2 of 4 pops, pulse arm -> next cycle state=1, count=0, rd_valid=0. New capture behaves per scenario 2.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the PC trace capture unit.
//   - tr_state_e : capture FSM state encoding (also driven out on the state port)
//   - TR_ONESHOT / TR_CIRC : values of the mode input
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        TR_IDLE    = 2'd0,
        TR_CAPTURE = 2'd1,
        TR_POST    = 2'd2,
        TR_DONE    = 2'd3
    } tr_state_e;

    localparam logic TR_ONESHOT = 1'b0;
    localparam logic TR_CIRC    = 1'b1;

endpackage

// File: rtl/pc_trace_buffer_if.sv
// Trace bus between the PC source / trace consumer and pc_trace_buffer.
//   pc, pc_valid      : committed PC stream tapped from the core
//   rd_valid, rd_ready: readout handshake, oldest entry first
//   rd_pc, rd_ts      : presented entry (zero when rd_valid is low)
// master = environment side, slave = pc_trace_buffer side.
interface pc_trace_buffer_if #(
    parameter int unsigned PC_W = 32,
    parameter int unsigned TS_W = 16
) ();
    logic [PC_W-1:0] pc;
    logic            pc_valid;
    logic            rd_valid;
    logic            rd_ready;
    logic [PC_W-1:0] rd_pc;
    logic [TS_W-1:0] rd_ts;

    modport master (
        output pc, pc_valid, rd_ready,
        input  rd_valid, rd_pc, rd_ts
    );

    modport slave (
        input  pc, pc_valid, rd_ready,
        output rd_valid, rd_pc, rd_ts
    );
endinterface

// File: rtl/trace_ram.sv
// Trace entry storage: DEPTH x W, one synchronous write port, one
// asynchronous read port. Contents are never reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module trace_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 48,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/pc_trace_buffer.sv
// PC trace capture unit. Records accepted committed PCs with a free-running
// timestamp into a circular buffer, in one-shot or trigger/post-trigger mode,
// and offers the captured entries oldest-first over a valid/ready handshake.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : PC input stream and readout handshake (slave modport)
//   arm       : one-cycle pulse, clears the buffer and starts capture
//   mode      : TR_ONESHOT or TR_CIRC
//   trig_en   : enable PC-match trigger on trig_pc
//   state     : FSM state
//   triggered : trigger seen since arm
//   count     : number of valid entries held
//   overflow  : entries overwritten since arm
module pc_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned TS_W      = 16,
    parameter int unsigned POST_TRIG = 8,
    parameter int unsigned CHG_ONLY  = 1,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned CW       = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    pc_trace_buffer_if.slave bus,
    input  logic             arm,
    input  logic             mode,
    input  logic             trig_en,
    input  logic [PC_W-1:0]  trig_pc,
    output logic [1:0]       state,
    output logic             triggered,
    output logic [CW-1:0]    count,
    output logic             overflow
);
    tr_state_e       state_q, state_d;
    logic [AW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic [AW-1:0]   post_cnt_q;
    logic [TS_W-1:0] ts_q;
    logic [PC_W-1:0] last_pc_q;
    logic            last_vld_q;
    logic            triggered_q;
    logic            overflow_q;

    logic            full, capturing, accept, trig_hit, wr_en, pop, cap_trig, post_last;
    logic            rd_valid;
    logic [AW-1:0]   rd_addr;
    logic [PC_W+TS_W-1:0] rd_data;

    assign full      = (count_q == CW'(DEPTH));
    assign capturing = (state_q == TR_CAPTURE) || (state_q == TR_POST);
    assign accept    = bus.pc_valid &&
                       ((CHG_ONLY == 0) || !last_vld_q || (bus.pc != last_pc_q));
    // Trigger looks at the raw PC, not the change filter.
    assign trig_hit  = trig_en && bus.pc_valid && (bus.pc == trig_pc);
    // One-shot never overwrites; it leaves CAPTURE on the filling write.
    assign wr_en     = !arm && capturing && accept && ((mode == TR_CIRC) || !full);
    assign rd_valid  = (state_q == TR_DONE) && (count_q != '0);
    assign pop       = !arm && rd_valid && bus.rd_ready;
    assign cap_trig  = !arm && (state_q == TR_CAPTURE) && trig_hit;
    assign post_last = (state_q == TR_POST) && wr_en && (post_cnt_q == AW'(1));

    // When full, the low bits of count are zero and the oldest entry is at wr_ptr.
    assign rd_addr   = wr_ptr_q - count_q[AW-1:0];

    trace_ram #(
        .DEPTH (DEPTH),
        .W     (PC_W + TS_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata ({bus.pc, ts_q}),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = TR_CAPTURE;
        end else begin
            unique case (state_q)
                TR_IDLE: state_d = TR_IDLE;
                TR_CAPTURE: begin
                    if (cap_trig) begin
                        state_d = ((mode == TR_CIRC) && (POST_TRIG != 0)) ? TR_POST : TR_DONE;
                    end else if ((mode == TR_ONESHOT) && wr_en &&
                                 (count_q == CW'(DEPTH - 1))) begin
                        state_d = TR_DONE;
                    end
                end
                TR_POST: begin
                    if (post_last) begin
                        state_d = TR_DONE;
                    end
                end
                TR_DONE: begin
                    if ((count_q == '0) || (pop && (count_q == CW'(1)))) begin
                        state_d = TR_IDLE;
                    end
                end
                default: state_d = TR_IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        bus.rd_valid = rd_valid;
        bus.rd_pc    = '0;
        bus.rd_ts    = '0;
        if (rd_valid) begin
            bus.rd_pc = rd_data[PC_W+TS_W-1:TS_W];
            bus.rd_ts = rd_data[TS_W-1:0];
        end
    end

    // Pointers, counters and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            count_q     <= '0;
            post_cnt_q  <= '0;
            ts_q        <= '0;
            last_pc_q   <= '0;
            last_vld_q  <= 1'b0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
            if (arm) begin
                wr_ptr_q    <= '0;
                count_q     <= '0;
                last_vld_q  <= 1'b0;
                triggered_q <= 1'b0;
                overflow_q  <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr_q   <= wr_ptr_q + AW'(1);
                    last_pc_q  <= bus.pc;
                    last_vld_q <= 1'b1;
                    if (full) begin
                        overflow_q <= 1'b1;
                    end else begin
                        count_q <= count_q + CW'(1);
                    end
                end else if (pop) begin
                    count_q <= count_q - CW'(1);
                end
                if (cap_trig) begin
                    triggered_q <= 1'b1;
                    post_cnt_q  <= AW'(POST_TRIG);
                end else if ((state_q == TR_POST) && wr_en) begin
                    post_cnt_q <= post_cnt_q - AW'(1);
                end
            end
        end
    end

    assign state     = state_q;
    assign triggered = triggered_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_pc_trace_buffer.sv
// Bench for pc_trace_buffer (DEPTH=4, POST_TRIG=2, CHG_ONLY=1, TS_W=16).
// Stimulus pushes expected {pc, ts} entries into a queue; a monitor pops and
// compares them whenever the DUT completes a readout handshake.
module tb_pc_trace_buffer;
    import cpu_trace_pkg::*;

    localparam int unsigned PC_W = 32;
    localparam int unsigned TS_W = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] ts;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic        mode;
    logic        trig_en;
    logic [31:0] trig_pc;
    logic [1:0]  state;
    logic        triggered;
    logic [2:0]  count;
    logic        overflow;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] m_ts;
    ent_t        sb[$];
    ent_t        mon_e;
    bit          chk_diff = 1'b0;
    bit          have_prev = 1'b0;
    logic [15:0] prev_ts;
    logic [15:0] d_ts;

    pc_trace_buffer_if #(.PC_W(PC_W), .TS_W(TS_W)) bus ();

    pc_trace_buffer #(
        .PC_W      (PC_W),
        .DEPTH     (4),
        .TS_W      (TS_W),
        .POST_TRIG (2),
        .CHG_ONLY  (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .arm       (arm),
        .mode      (mode),
        .trig_en   (trig_en),
        .trig_pc   (trig_pc),
        .state     (state),
        .triggered (triggered),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference timestamp: cleared by reset, +1 every cycle, wraps at 16 bits.
    always @(posedge clk) begin
        if (rst) m_ts <= 16'd0;
        else     m_ts <= m_ts + 16'd1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen at negedge completes at the next posedge.
    always @(negedge clk) begin
        if (!rst && bus.rd_valid && bus.rd_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got pc %0h expected no entry", bus.rd_pc);
            end else begin
                mon_e = sb.pop_front();
                check("rd_pc", {32'd0, bus.rd_pc}, {32'd0, mon_e.pc});
                check("rd_ts", {48'd0, bus.rd_ts}, {48'd0, mon_e.ts});
                if (chk_diff) begin
                    if (have_prev) begin
                        d_ts = bus.rd_ts - prev_ts;
                        check("ts_delta", {48'd0, d_ts}, 64'd3);
                    end
                    prev_ts   = bus.rd_ts;
                    have_prev = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] p, input bit keep);
        bus.pc       = p;
        bus.pc_valid = 1'b1;
        if (keep) sb.push_back({p, m_ts});
        step();
        bus.pc_valid = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        bus.rd_ready = 1'b1;
        while (state != TR_IDLE && n < 20) begin
            step();
            n++;
        end
        bus.rd_ready = 1'b0;
        check({name, "_idle"}, {62'd0, state}, 64'd0);
        check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic fill_basic();
        do_arm();
        check("arm_state", {62'd0, state}, {62'd0, TR_CAPTURE});
        send(32'h0, 1'b1);
        send(32'h4, 1'b1);
        send(32'h4, 1'b0);
        send(32'h8, 1'b1);
        send(32'hC, 1'b1);
        check("fill_state", {62'd0, state}, {62'd0, TR_DONE});
        check("fill_count", {61'd0, count}, 64'd4);
        check("fill_rd_pc", {32'd0, bus.rd_pc}, 64'h0);
    endtask

    initial begin
        logic [5:0]  pat;
        logic [31:0] ppc;
        logic [15:0] pts;
        int          n;

        rst = 1'b1; arm = 1'b0; mode = TR_ONESHOT; trig_en = 1'b0; trig_pc = '0;
        bus.pc = '0; bus.pc_valid = 1'b0; bus.rd_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_state", {62'd0, state}, 64'd0);
        check("rst_count", {61'd0, count}, 64'd0);
        check("rst_rd_valid", {63'd0, bus.rd_valid}, 64'd0);

        // 1: reset in the middle of a capture
        do_arm();
        send(32'h10, 1'b0);
        send(32'h14, 1'b0);
        send(32'h18, 1'b0);
        check("s1_state", {62'd0, state}, {62'd0, TR_CAPTURE});
        check("s1_count", {61'd0, count}, 64'd3);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("s1_rst_state", {62'd0, state}, 64'd0);
        check("s1_rst_count", {61'd0, count}, 64'd0);
        check("s1_rst_rd_valid", {63'd0, bus.rd_valid}, 64'd0);
        check("s1_rst_rd_pc", {32'd0, bus.rd_pc}, 64'd0);
        check("s1_rst_overflow", {63'd0, overflow}, 64'd0);
        check("s1_rst_triggered", {63'd0, triggered}, 64'd0);

        // 2: one-shot fill with a duplicate dropped
        fill_basic();
        drain("s2");

        // 3: circular capture, trigger at 0x20 after overflow
        mode = TR_CIRC; trig_en = 1'b1; trig_pc = 32'h20;
        do_arm();
        for (int i = 0; i < 11; i++) begin
            send(32'(4 * i), (4 * i) >= 32'h1C);
            if (i == 7) check("s3_pre_trig", {63'd0, triggered}, 64'd0);
            if (i == 8) begin
                check("s3_triggered", {63'd0, triggered}, 64'd1);
                check("s3_post", {62'd0, state}, {62'd0, TR_POST});
            end
        end
        trig_en = 1'b0;
        check("s3_state", {62'd0, state}, {62'd0, TR_DONE});
        check("s3_overflow", {63'd0, overflow}, 64'd1);
        check("s3_count", {61'd0, count}, 64'd4);
        drain("s3");

        // 4: backpressure during readout
        mode = TR_ONESHOT;
        do_arm();
        for (int i = 0; i < 4; i++) send(32'h100 + 32'(4 * i), 1'b1);
        pat = 6'b111001;
        for (int i = 0; i < 6; i++) begin
            bus.rd_ready = pat[i];
            ppc = bus.rd_pc;
            pts = bus.rd_ts;
            step();
            if (!pat[i]) begin
                check("s4_hold_pc", {32'd0, bus.rd_pc}, {32'd0, ppc});
                check("s4_hold_ts", {48'd0, bus.rd_ts}, {48'd0, pts});
            end
        end
        bus.rd_ready = 1'b0;
        check("s4_rd_valid", {63'd0, bus.rd_valid}, 64'd0);
        check("s4_rd_pc_zero", {32'd0, bus.rd_pc}, 64'd0);
        check("s4_state", {62'd0, state}, 64'd0);
        check("s4_sb_empty", 64'(sb.size()), 64'd0);

        // 5a: samples every third cycle, armed at ts=100
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        while (m_ts != 16'd100 && n < 200) begin
            step();
            n++;
        end
        check("s5_wait100", {48'd0, m_ts}, 64'd100);
        do_arm();
        chk_diff = 1'b1; have_prev = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send(32'h200 + 32'(4 * k), 1'b1);
            step();
            step();
        end
        check("s5_state", {62'd0, state}, {62'd0, TR_DONE});
        drain("s5");

        // 5b: same pattern across the timestamp wrap
        n = 0;
        while (m_ts != 16'hFFFD && n < 70000) begin
            step();
            n++;
        end
        check("s5_wait_wrap", {48'd0, m_ts}, 64'hFFFD);
        do_arm();
        have_prev = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send(32'h300 + 32'(4 * k), 1'b1);
            step();
            step();
        end
        drain("s5w");
        chk_diff = 1'b0;

        // 6: re-arm halfway through a readout
        do_arm();
        for (int i = 0; i < 4; i++) send(32'h400 + 32'(4 * i), 1'b1);
        bus.rd_ready = 1'b1;
        step();
        step();
        bus.rd_ready = 1'b0;
        check("s6_count_mid", {61'd0, count}, 64'd2);
        arm = 1'b1;
        step();
        arm = 1'b0;
        sb.delete();
        check("s6_state", {62'd0, state}, {62'd0, TR_CAPTURE});
        check("s6_count", {61'd0, count}, 64'd0);
        check("s6_rd_valid", {63'd0, bus.rd_valid}, 64'd0);
        send(32'h0, 1'b1);
        send(32'h4, 1'b1);
        send(32'h4, 1'b0);
        send(32'h8, 1'b1);
        send(32'hC, 1'b1);
        check("s6_fill_state", {62'd0, state}, {62'd0, TR_DONE});
        check("s6_fill_count", {61'd0, count}, 64'd4);
        drain("s6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
